multi_clock_synthesizer: RTL and testbench
==========================================

# multi_clock_synthesizer

Multi-channel, run-time programmable clock synthesizer. Each channel divides the single system clock by an arbitrary period N and produces an output with a programmable high time H, so duty cycle is not fixed at 50%. New settings are applied glitch-free, and a sync strobe phase-aligns all channels. The block sits beside the fixed-ratio synthesizers and drives LED/PWM, baud and sampling strobes that software retunes at run time.

## Interface

Parameters:
- `CHANNELS`, 4: number of independent output channels (≥1).
- `BITS`, 16: width of the period, high-time and counter fields.
- `IN_FREQ`, 1000000: input clock frequency in Hz; used only for reset defaults.
- `OUT_FREQ`, 1000: reset output frequency in Hz.
  - Reset period is RST_N = IN_FREQ / OUT_FREQ (integer division).
  - Reset high time is RST_H = RST_N / 2.
  - Both must fit in BITS.

Ports:
- `inclock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  CHANNELS  per-channel run enable, level-sensitive.
- `load`  in  1  one-cycle write strobe.
- `load_channel`  in  clog2(CHANNELS) (min 1)  channel selected by `load`.
- `load_period`  in  BITS  new period N in cycles.
- `load_high`  in  BITS  new high time H in cycles.
- `sync`  in  1  one-cycle strobe that restarts all enabled channels in phase.
- `outclock`  out  CHANNELS  synthesized clocks, registered.
- `tick`  out  CHANNELS  one-cycle pulse per output period, registered.

## Operation

- Per-channel state:
  - active N and H, used by the counter;
  - shadow N and H, plus a `pending` flag;
  - counter `cnt` (BITS).
- A channel is valid when active N ≥ 2.
  - An invalid channel holds `outclock`=0 and `tick`=0, with `cnt` held at 0.
- Disabled channel (`enable[i]`=0):
  - `outclock`=0, `tick`=0, and `cnt` parked at N−1.
  - A `load` to it copies shadow into active immediately and re-parks `cnt` at new N−1.
- Enabled, valid channel, each cycle:
  - cnt_next = (cnt == N−1) ? 0 : cnt+1.
  - `outclock` <= (cnt_next < H).
  - `tick` <= (cnt_next == 0) && (H > 0).
- Because disabled channels park at N−1, the first enabled cycle wraps to 0. The output starts with a full high phase and a tick.
- Duty cycle boundaries:
  - H=0: constant low, no tick.
  - H ≥ N: constant high, tick still pulses every wrap.
- `load` to an enabled channel:
  - Writes shadow and sets `pending`.
  - At the next wrap (the cycle where cnt_next == 0), shadow is copied to active, `pending` clears, and the new N/H govern that same cycle's `outclock` and `tick`.
  - A second `load` before the wrap overwrites shadow; last write wins.
- Shrinking N below the current `cnt` is safe: the change applies only at a wrap, so there is no runaway count.
- `load_channel` ≥ CHANNELS: the write is ignored.
- `sync`, applied to every enabled channel:
  - Apply shadow if pending, then set cnt_next = 0.
  - This is treated as a wrap, so `outclock` and `tick` follow the wrap rules.
  - A `load` in the same cycle is captured into shadow first, so sync applies it.
  - Disabled channels ignore `sync`.
- Reset, at any time including mid-period:
  - Active and shadow set to RST_N/RST_H; `pending`=0.
  - `cnt` = RST_N−1; all `outclock`=0 and `tick`=0.
- Counter arithmetic is unsigned BITS-wide. N−1 and comparisons never overflow because N ≥ 2 is enforced via the validity rule.

## Timing

- Latency: `enable` rising at edge k gives `outclock`=1 (if H>0) and `tick`=1 after edge k+1.
- Output period is exactly N cycles, with high for min(H,N) cycles. There are no glitches, since outputs come straight from flops.
- `tick` is coincident with the `outclock` rising cycle, except when H ≥ N, where `outclock` stays high.
- `load` on an enabled channel takes effect at the next wrap, between 1 and N cycles later.
- `sync` gives all enabled channels `outclock` high (if H>0) and `tick`=1 on the cycle after the strobe.
- `enable` falling gives `outclock`=0 on the next cycle, truncating the current period.

## Test plan

- Reset with IN_FREQ=1000000, OUT_FREQ=1000, then enable ch0 → ch0 period 1000 cycles, high 500; tick every 1000 cycles; first tick one cycle after enable.
- Load ch1 N=5, H=2 while disabled, then enable → pattern 1,1,0,0,0 repeating; tick on each first 1.
- Load ch0 N=4, H=1 mid-period of N=10, H=5 → old period finishes at cnt 9; new 4-cycle, 25% waveform starts exactly at the wrap, with no short pulses.
- Boundaries on ch2: H=0 gives constant 0 and no tick; H=7 with N=5 gives constant 1 with a tick every 5 cycles; N=1 gives constant 0 and no tick.
- Channels with N=3, 5, 7 free-running, `sync` pulse → all `tick` and `outclock` high on the same cycle; realigned every 105 cycles.
- Assert `reset` mid-high-phase → next cycle all `outclock`/`tick`=0 and pending loads discarded; after release the defaults are restored.

Source files
------------

// File: rtl/multi_clock_synthesizer.sv
// Multi-channel programmable clock synthesizer: per-channel period N and high time H,
// glitch-free retune at period wrap, and a sync strobe that phase-aligns enabled channels.
module multi_clock_synthesizer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BITS     = 16,
    parameter int unsigned IN_FREQ  = 1000000,
    parameter int unsigned OUT_FREQ = 1000,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                inclock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                load,
    input  logic [CW-1:0]       load_channel,
    input  logic [BITS-1:0]     load_period,
    input  logic [BITS-1:0]     load_high,
    input  logic                sync,
    output logic [CHANNELS-1:0] outclock,
    output logic [CHANNELS-1:0] tick
);

    localparam int unsigned     RST_NI = IN_FREQ / OUT_FREQ;
    localparam logic [BITS-1:0] RST_N  = BITS'(RST_NI);
    localparam logic [BITS-1:0] RST_H  = BITS'(RST_NI / 2);
    localparam logic [BITS-1:0] ONE    = BITS'(1);
    localparam logic [BITS-1:0] TWO    = BITS'(2);

    logic [BITS-1:0]     act_n   [CHANNELS];
    logic [BITS-1:0]     act_h   [CHANNELS];
    logic [BITS-1:0]     sh_n    [CHANNELS];
    logic [BITS-1:0]     sh_h    [CHANNELS];
    logic [BITS-1:0]     cnt     [CHANNELS];
    logic [CHANNELS-1:0] pending;

    logic [BITS-1:0]     act_n_d [CHANNELS];
    logic [BITS-1:0]     act_h_d [CHANNELS];
    logic [BITS-1:0]     sh_n_d  [CHANNELS];
    logic [BITS-1:0]     sh_h_d  [CHANNELS];
    logic [BITS-1:0]     cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] pending_d;
    logic [CHANNELS-1:0] outclock_d;
    logic [CHANNELS-1:0] tick_d;

    // Per-channel next state; an invalid active N (<2) is treated as wrapping every cycle
    // so a pending setting or sync can bring the channel back.
    always_comb begin
        logic sel;
        logic wrap;
        sel        = 1'b0;
        wrap       = 1'b0;
        pending_d  = pending;
        outclock_d = '0;
        tick_d     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            act_n_d[i] = act_n[i];
            act_h_d[i] = act_h[i];
            sh_n_d[i]  = sh_n[i];
            sh_h_d[i]  = sh_h[i];
            cnt_d[i]   = cnt[i];
            sel        = load && (load_channel == CW'(i));
            if (!enable[i]) begin
                if (sel) begin
                    sh_n_d[i]    = load_period;
                    sh_h_d[i]    = load_high;
                    act_n_d[i]   = load_period;
                    act_h_d[i]   = load_high;
                    pending_d[i] = 1'b0;
                end
                cnt_d[i] = (act_n_d[i] >= TWO) ? act_n_d[i] - ONE : '0;
            end else begin
                if (sel) begin
                    sh_n_d[i]    = load_period;
                    sh_h_d[i]    = load_high;
                    pending_d[i] = 1'b1;
                end
                wrap = sync || (act_n[i] < TWO) || (cnt[i] == act_n[i] - ONE);
                if (wrap) begin
                    if (pending_d[i]) begin
                        act_n_d[i]   = sh_n_d[i];
                        act_h_d[i]   = sh_h_d[i];
                        pending_d[i] = 1'b0;
                    end
                    cnt_d[i] = '0;
                    if (act_n_d[i] >= TWO) begin
                        outclock_d[i] = (act_h_d[i] != '0);
                        tick_d[i]     = (act_h_d[i] != '0);
                    end
                end else begin
                    cnt_d[i]      = cnt[i] + ONE;
                    outclock_d[i] = (cnt_d[i] < act_h[i]);
                end
            end
        end
    end

    always_ff @(posedge inclock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                act_n[i] <= RST_N;
                act_h[i] <= RST_H;
                sh_n[i]  <= RST_N;
                sh_h[i]  <= RST_H;
                cnt[i]   <= RST_N - ONE;
            end
            pending  <= '0;
            outclock <= '0;
            tick     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                act_n[i] <= act_n_d[i];
                act_h[i] <= act_h_d[i];
                sh_n[i]  <= sh_n_d[i];
                sh_h[i]  <= sh_h_d[i];
                cnt[i]   <= cnt_d[i];
            end
            pending  <= pending_d;
            outclock <= outclock_d;
            tick     <= tick_d;
        end
    end

endmodule

// File: tb/tb_multi_clock_synthesizer.sv
// Directed bench for multi_clock_synthesizer: cycle tables for retune/boundary cases,
// plus hand sequences for reset defaults, sync alignment and reset mid-period.
module tb_multi_clock_synthesizer;

    logic        inclock;
    logic        reset;
    logic [3:0]  enable;
    logic        load;
    logic [1:0]  load_channel;
    logic [15:0] load_period;
    logic [15:0] load_high;
    logic        sync;
    logic [3:0]  outclock;
    logic [3:0]  tick;

    int total;
    int bad;

    typedef struct packed {
        logic [3:0]  en;
        logic        ld;
        logic [1:0]  ch;
        logic [15:0] n;
        logic [15:0] h;
        logic        sy;
        logic [3:0]  eo;
        logic [3:0]  et;
    } vec_t;

    vec_t tbl[$];

    multi_clock_synthesizer #(
        .CHANNELS(4), .BITS(16), .IN_FREQ(1000000), .OUT_FREQ(1000)
    ) dut (
        .inclock(inclock), .reset(reset), .enable(enable), .load(load),
        .load_channel(load_channel), .load_period(load_period), .load_high(load_high),
        .sync(sync), .outclock(outclock), .tick(tick)
    );

    initial inclock = 1'b0;
    always #5 inclock = ~inclock;

    function automatic vec_t v(input logic [3:0] en, input logic ld, input logic [1:0] ch,
                               input int n, input int h, input logic [3:0] eo,
                               input logic [3:0] et);
        vec_t r;
        r.en = en; r.ld = ld; r.ch = ch; r.n = 16'(n); r.h = 16'(h);
        r.sy = 1'b0; r.eo = eo; r.et = et;
        return r;
    endfunction

    task automatic step();
        @(posedge inclock);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] en, input logic ld, input logic [1:0] ch,
                         input int n, input int h, input logic sy);
        enable = en; load = ld; load_channel = ch;
        load_period = 16'(n); load_high = 16'(h); sync = sy;
    endtask

    initial begin
        logic [3:0] eo;
        logic [3:0] et;
        int nper[4];
        int hper[4];
        total = 0;
        bad   = 0;

        // Retune ch0 mid-period (10/5 -> 6/3 overwritten by 4/1); also enable-fall truncation.
        tbl.push_back(v(4'b0000, 1, 0, 10, 5, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000));
        tbl.push_back(v(4'b0001, 1, 0, 6, 3, 4'b0001, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 1, 0, 4, 1, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001));
        // ch1 loaded 5/2 while disabled, then enabled.
        tbl.push_back(v(4'b0000, 1, 1, 5, 2, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0010));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000));
        tbl.push_back(v(4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000));
        // ch2 boundaries: H=0, then H=7>N=5, then N=1.
        tbl.push_back(v(4'b0000, 1, 2, 5, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 1, 2, 5, 7, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0100));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0100));
        tbl.push_back(v(4'b0100, 1, 2, 1, 1, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));

        // Reset state
        reset = 1'b1;
        drive(4'b0000, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset_outclock", outclock, 4'b0000);
        chk("reset_tick", tick, 4'b0000);

        // Reset defaults on ch0: period 1000, high 500, first tick one cycle after enable
        reset = 1'b0;
        drive(4'b0001, 0, 0, 0, 0, 0);
        for (int j = 0; j <= 2000; j++) begin
            step();
            chk("default_out", outclock, {3'b000, 1'((j % 1000) < 500)});
            chk("default_tick", tick, {3'b000, 1'((j % 1000) == 0)});
        end

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].en, tbl[r].ld, tbl[r].ch, int'(tbl[r].n), int'(tbl[r].h), tbl[r].sy);
            step();
            chk($sformatf("tbl%0d_out", r), outclock, tbl[r].eo);
            chk($sformatf("tbl%0d_tick", r), tick, tbl[r].et);
        end

        // Misaligned free-running 3/1, 5/2, 7/3 on ch1..3
        drive(4'b0000, 1, 1, 3, 1, 0); step();
        drive(4'b0000, 1, 2, 5, 2, 0); step();
        drive(4'b0000, 1, 3, 7, 3, 0); step();
        drive(4'b0010, 0, 0, 0, 0, 0); step(); step();
        drive(4'b0110, 0, 0, 0, 0, 0); step();
        drive(4'b1110, 0, 0, 0, 0, 0); step(); step(); step(); step();

        // Sync with a same-cycle load of ch3 to 7/4; sync must apply it
        nper = '{1, 3, 5, 7};
        hper = '{0, 1, 2, 4};
        for (int j = 0; j <= 210; j++) begin
            if (j == 0) drive(4'b1110, 1, 3, 7, 4, 1);
            else        drive(4'b1110, 0, 0, 0, 0, 0);
            step();
            eo = '0;
            et = '0;
            for (int c = 1; c < 4; c++) begin
                eo[c] = 1'((j % nper[c]) < hper[c]);
                et[c] = 1'((j % nper[c]) == 0);
            end
            chk($sformatf("sync_out_j%0d", j), outclock, eo);
            chk($sformatf("sync_tick_j%0d", j), tick, et);
        end

        // Pending load on ch3, then reset mid-high-phase of ch2/ch3
        drive(4'b1110, 1, 3, 9, 1, 0);
        step();
        chk("preload_out", outclock, 4'b1100);
        chk("preload_tick", tick, 4'b0000);
        drive(4'b1110, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk("midreset_out", outclock, 4'b0000);
        chk("midreset_tick", tick, 4'b0000);
        reset = 1'b0;
        for (int j = 0; j <= 1000; j++) begin
            step();
            eo = {3{1'((j % 1000) < 500)}} << 1;
            et = {3{1'((j % 1000) == 0)}} << 1;
            chk("postreset_out", outclock, eo);
            chk("postreset_tick", tick, et);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
